gru_hidden_update: RTL and testbench

- Final GRU stage, directly downstream of the per-element candidate (n_t) and update (z_t) gate elements.
- Accepts (index, z_t_n, n_t_n) tuples in any order and computes h_t[n] = (1 - z_t_n)*n_t_n + z_t_n*h_t_prev[n] in fixed point.
- Assembles all H results into a staging buffer, then commits the vector atomically as the new h_t_prev.
- h_t_prev is the registered state vector fed back to all gate elements for the next timestep.

---
 rtl/gru_hidden_update.sv | 155 +++++++++++++++
 tb/tb_gru_hidden_update.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gru_hidden_update.sv
// -----------------------------------------------------------------------------
// gru_hidden_update
//
// Final GRU stage. Takes per-element (index, z, n) tuples in any order and
// computes h[n] = n + ((z * (h_prev[idx] - n)) >>> FRAC_BITS), saturated to the
// signed DATA_WIDTH range. Results collect in a staging buffer. When all H
// elements have arrived, the buffer is committed to h_t_prev in a single edge.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   clear_state  : synchronous clear of committed state; aborts the timestep
//   start        : begin a timestep (honoured only in IDLE)
//   elem_valid   : element tuple valid
//   elem_ready   : element tuple accepted when elem_valid && elem_ready
//   elem_idx     : hidden element index
//   z_t_n        : update gate value, signed Q(FRAC_BITS)
//   n_t_n        : candidate value, signed Q(FRAC_BITS)
//   h_t_prev     : committed hidden state vector
//   h_t_valid    : one-cycle pulse when h_t_prev has just been updated
//   busy         : high in COLLECT and COMMIT
//   err_dup      : one-cycle pulse when a duplicate or out-of-range tuple is dropped
// -----------------------------------------------------------------------------
module gru_hidden_update #(
  parameter int H          = 256,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IDX_WIDTH  = $clog2(H)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear_state,
  input  logic                                start,
  input  logic                                elem_valid,
  output logic                                elem_ready,
  input  logic [IDX_WIDTH-1:0]                elem_idx,
  input  logic signed [DATA_WIDTH-1:0]        z_t_n,
  input  logic signed [DATA_WIDTH-1:0]        n_t_n,
  output logic [H-1:0][DATA_WIDTH-1:0]        h_t_prev,
  output logic                                h_t_valid,
  output logic                                busy,
  output logic                                err_dup
);

  localparam int DW    = DATA_WIDTH;
  localparam int SEL_W = (H > 1) ? $clog2(H) : 1;
  localparam int CNT_W = $clog2(H + 1);

  // Saturation bounds at the full sum width.
  localparam logic signed [2*DW+1:0] SAT_MAX = {{(DW+3){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW+1:0] SAT_MIN = {{(DW+3){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_COMMIT
  } state_t;

  state_t                     r_state;
  logic [H-1:0][DW-1:0]       r_staging;
  logic [H-1:0]               r_seen;
  logic [CNT_W-1:0]           r_count;

  logic                       w_accept;
  logic                       w_in_range;
  logic [SEL_W-1:0]           w_sel;
  logic signed [DW-1:0]       w_h_sel;
  logic signed [DW:0]         w_diff;
  logic signed [2*DW:0]       w_prod;
  logic signed [2*DW:0]       w_shift;
  logic signed [2*DW+1:0]     w_sum;
  logic signed [DW-1:0]       w_result;

  assign elem_ready = (r_state == S_COLLECT);
  assign busy       = (r_state != S_IDLE);
  assign w_accept   = elem_valid && elem_ready;

  // The index port may be wider than needed, so check the range explicitly.
  // Out-of-range indices select element 0 only to keep the datapath defined;
  // their result is never stored.
  assign w_in_range = (int'(elem_idx) < H);
  assign w_sel      = w_in_range ? SEL_W'(elem_idx) : '0;

  // Read the committed state, never the staging buffer, so a timestep does
  // not see its own partial results.
  assign w_h_sel  = h_t_prev[w_sel];
  assign w_diff   = {w_h_sel[DW-1], w_h_sel} - {n_t_n[DW-1], n_t_n};
  assign w_prod   = (2*DW+1)'(z_t_n) * (2*DW+1)'(w_diff);
  assign w_shift  = w_prod >>> FRAC_BITS;
  assign w_sum    = (2*DW+2)'(w_shift) + (2*DW+2)'(n_t_n);
  assign w_result = (w_sum > SAT_MAX) ? SAT_MAX[DW-1:0] :
                    (w_sum < SAT_MIN) ? SAT_MIN[DW-1:0] :
                                        w_sum[DW-1:0];

  // NOTE: every register in this block uses non-blocking assignments, so all
  // reads within one edge see the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      h_t_prev  <= '0;
      // NOTE: the staging buffer is reset like ordinary flops. It is a
      // register array here, not a RAM, and it must read back as zero after
      // reset or clear.
      r_staging <= '0;
      r_seen    <= '0;
      r_count   <= '0;
      h_t_valid <= 1'b0;
      err_dup   <= 1'b0;
    end else begin
      h_t_valid <= 1'b0;
      err_dup   <= 1'b0;
      if (clear_state) begin
        // Clear wins over start and over any handshake in the same cycle.
        r_state   <= S_IDLE;
        h_t_prev  <= '0;
        r_staging <= '0;
        r_seen    <= '0;
        r_count   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_COLLECT;
              r_seen  <= '0;
              r_count <= '0;
            end
          end
          S_COLLECT: begin
            if (w_accept) begin
              if (w_in_range && !r_seen[w_sel]) begin
                r_staging[w_sel] <= w_result;
                r_seen[w_sel]    <= 1'b1;
                r_count          <= r_count + CNT_W'(1);
                if (r_count == CNT_W'(H - 1)) begin
                  r_state <= S_COMMIT;
                end
              end else begin
                err_dup <= 1'b1;
              end
            end
          end
          S_COMMIT: begin
            h_t_prev  <= r_staging;
            h_t_valid <= 1'b1;
            r_state   <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gru_hidden_update.sv
`timescale 1ns/1ps
module tb_gru_hidden_update;

  localparam int H  = 4;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int IW = 4;  // wide enough to present out-of-range index 9

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clear_state;
  logic                 start;
  logic                 elem_valid;
  logic                 elem_ready;
  logic [IW-1:0]        elem_idx;
  logic [DW-1:0]        z_t_n;
  logic [DW-1:0]        n_t_n;
  logic [H-1:0][DW-1:0] h_t_prev;
  logic                 h_t_valid;
  logic                 busy;
  logic                 err_dup;

  int n_checks = 0;
  int n_errors = 0;

  gru_hidden_update #(
    .H          (H),
    .DATA_WIDTH (DW),
    .FRAC_BITS  (FB),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_state (clear_state),
    .start       (start),
    .elem_valid  (elem_valid),
    .elem_ready  (elem_ready),
    .elem_idx    (elem_idx),
    .z_t_n       (z_t_n),
    .n_t_n       (n_t_n),
    .h_t_prev    (h_t_prev),
    .h_t_valid   (h_t_valid),
    .busy        (busy),
    .err_dup     (err_dup)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] vec(input logic [15:0] a3, input logic [15:0] a2,
                                      input logic [15:0] a1, input logic [15:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input logic [15:0] z, input logic [15:0] n);
    elem_valid = 1'b1;
    elem_idx   = IW'(idx);
    z_t_n      = z;
    n_t_n      = n;
    step();
    elem_valid = 1'b0;
  endtask

  task automatic begin_ts(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    check({tag, " ready in collect"}, 64'(elem_ready), 64'd1);
  endtask

  // Called right after the edge that accepted the last tuple.
  task automatic finish_commit(input string tag, input logic [63:0] exp);
    check({tag, " no valid before commit"}, 64'(h_t_valid), 64'd0);
    check({tag, " ready low in commit"}, 64'(elem_ready), 64'd0);
    check({tag, " busy in commit"}, 64'(busy), 64'd1);
    step();
    check({tag, " valid pulse"}, 64'(h_t_valid), 64'd1);
    check({tag, " h_t_prev"}, h_t_prev, exp);
    step();
    check({tag, " valid one cycle"}, 64'(h_t_valid), 64'd0);
    check({tag, " idle after"}, 64'(busy), 64'd0);
  endtask

  // z = 0 makes h = n exactly, which loads arbitrary state for later tests.
  task automatic load(input string tag, input logic [15:0] v3, input logic [15:0] v2,
                      input logic [15:0] v1, input logic [15:0] v0);
    begin_ts(tag);
    send(0, 16'h0000, v0);
    send(1, 16'h0000, v1);
    send(2, 16'h0000, v2);
    send(3, 16'h0000, v3);
    finish_commit(tag, vec(v3, v2, v1, v0));
  endtask

  initial begin
    rst_n       = 1'b0;
    clear_state = 1'b0;
    start       = 1'b0;
    elem_valid  = 1'b0;
    elem_idx    = '0;
    z_t_n       = '0;
    n_t_n       = '0;
    #12;
    check("reset h_t_prev", h_t_prev, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset ready", 64'(elem_ready), 64'd0);
    check("reset valid", 64'(h_t_valid), 64'd0);
    check("reset err_dup", 64'(err_dup), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: h_prev = 0, z = 0.5, n = 1.0 -> 0.5 everywhere
    begin_ts("ts1");
    for (int i = 0; i < H; i++) send(i, 16'h0080, 16'h0100);
    finish_commit("ts1", vec(16'h0080, 16'h0080, 16'h0080, 16'h0080));

    // 2: h_prev = 3.0, z = 0.5, n = 1.0, out of order -> 2.0
    load("load300", 16'h0300, 16'h0300, 16'h0300, 16'h0300);
    begin_ts("ts2");
    send(3, 16'h0080, 16'h0100);
    send(1, 16'h0080, 16'h0100);
    send(0, 16'h0080, 16'h0100);
    check("ts2 state held mid collect", h_t_prev,
          vec(16'h0300, 16'h0300, 16'h0300, 16'h0300));
    send(2, 16'h0080, 16'h0100);
    check("ts2 state held before commit", h_t_prev,
          vec(16'h0300, 16'h0300, 16'h0300, 16'h0300));
    finish_commit("ts2", vec(16'h0200, 16'h0200, 16'h0200, 16'h0200));

    // 3: saturation, z = 1.0, floor rounding of negative products
    load("loadsat", 16'h0000, 16'h0000, 16'h8000, 16'h7FFF);
    begin_ts("ts3");
    send(0, 16'h7FFF, 16'h8000);  // saturates high -> 0x7FFF
    send(1, 16'h0100, 16'h7FFF);  // z = 1.0 -> h_prev = 0x8000
    send(2, 16'h0001, 16'h0001);  // 1 + floor(-1/256) = 0
    send(3, 16'h0080, 16'h0101);  // 257 + floor(-128.5) = 128
    finish_commit("ts3", vec(16'h0080, 16'h0000, 16'h8000, 16'h7FFF));

    // 4: duplicate idx 2, out-of-range idx 9
    begin_ts("ts4");
    send(2, 16'h0000, 16'h1111);
    check("ts4 no err first idx2", 64'(err_dup), 64'd0);
    send(0, 16'h0000, 16'h0A0A);
    send(1, 16'h0000, 16'h0B0B);
    send(2, 16'h0000, 16'h2222);
    check("ts4 err dup idx2", 64'(err_dup), 64'd1);
    step();
    check("ts4 err pulse ends", 64'(err_dup), 64'd0);
    send(9, 16'h0000, 16'h3333);
    check("ts4 err idx9", 64'(err_dup), 64'd1);
    check("ts4 still collecting", 64'(elem_ready), 64'd1);
    send(3, 16'h0000, 16'h0D0D);
    check("ts4 no err idx3", 64'(err_dup), 64'd0);
    finish_commit("ts4", vec(16'h0D0D, 16'h1111, 16'h0B0B, 16'h0A0A));

    // 5: clear_state with start and a tuple in the same cycle
    begin_ts("ts5");
    send(0, 16'h0080, 16'h0100);
    send(1, 16'h0080, 16'h0100);
    clear_state = 1'b1;
    start       = 1'b1;
    elem_valid  = 1'b1;
    elem_idx    = IW'(2);
    step();
    clear_state = 1'b0;
    start       = 1'b0;
    elem_valid  = 1'b0;
    check("clr h_t_prev", h_t_prev, 64'd0);
    check("clr busy", 64'(busy), 64'd0);
    check("clr ready", 64'(elem_ready), 64'd0);
    check("clr no valid", 64'(h_t_valid), 64'd0);
    step();
    check("clr start ignored", 64'(busy), 64'd0);
    check("clr still no valid", 64'(h_t_valid), 64'd0);

    // 6: asynchronous reset between edges mid-collect
    load("load505", 16'h0505, 16'h0505, 16'h0505, 16'h0505);
    begin_ts("ts6");
    send(0, 16'h0080, 16'h0100);
    send(1, 16'h0080, 16'h0100);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst h_t_prev", h_t_prev, 64'd0);
    check("arst busy", 64'(busy), 64'd0);
    check("arst ready", 64'(elem_ready), 64'd0);
    #2;
    rst_n = 1'b1;
    step();
    begin_ts("ts7");
    for (int i = 0; i < H; i++) send(i, 16'h0080, 16'h0100);
    finish_commit("ts7", vec(16'h0080, 16'h0080, 16'h0080, 16'h0080));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
